// File: rtl/freq_detector.sv
// Detects which divided-clock ratio (2/4/8/16) sig_i runs at and locks onto it
// after two matching periods; faults (illegal period, ratio change, timeout) pulse error_o.
module freq_detector (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       sig_i,
    output logic [1:0] selector_o,
    output logic       valid_o,
    output logic       error_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t     state_reg, state_next;
    logic       sig_q;
    logic [4:0] cnt_reg, cnt_next;
    logic       cand_valid_reg, cand_valid_next;
    logic [1:0] cand_code_reg, cand_code_next;
    logic [1:0] selector_next;
    logic       valid_next, error_next;

    logic       rise;
    logic       legal;
    logic [1:0] code;
    logic       saturated;

    assign rise      = sig_i & ~sig_q;
    assign saturated = (cnt_reg == 5'd31);

    // The counter value seen on a rise is the period just completed.
    always_comb begin
        legal = 1'b1;
        code  = 2'b00;
        case (cnt_reg)
            5'd2:    code = 2'b00;
            5'd4:    code = 2'b01;
            5'd8:    code = 2'b10;
            5'd16:   code = 2'b11;
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        cnt_next = cnt_reg;
        if (rise)
            cnt_next = 5'd1;
        else if (!saturated)
            cnt_next = cnt_reg + 5'd1;
    end

    always_comb begin
        state_next      = state_reg;
        cand_valid_next = cand_valid_reg;
        cand_code_next  = cand_code_reg;
        selector_next   = selector_o;
        error_next      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (rise) begin
                    state_next      = MEASURE;
                    cand_valid_next = 1'b0;
                end
            end
            MEASURE: begin
                if (rise) begin
                    if (!legal) begin
                        error_next      = 1'b1;
                        cand_valid_next = 1'b0;
                    end else if (cand_valid_reg && (cand_code_reg == code)) begin
                        state_next    = LOCKED;
                        selector_next = code;
                    end else begin
                        cand_valid_next = 1'b1;
                        cand_code_next  = code;
                    end
                end else if (saturated) begin
                    state_next      = IDLE;
                    cand_valid_next = 1'b0;
                    error_next      = 1'b1;
                end
            end
            LOCKED: begin
                if (rise) begin
                    if (!legal) begin
                        error_next      = 1'b1;
                        cand_valid_next = 1'b0;
                        state_next      = MEASURE;
                    end else if (code != selector_o) begin
                        // New legal ratio becomes the candidate so re-lock needs one more match.
                        error_next      = 1'b1;
                        cand_valid_next = 1'b1;
                        cand_code_next  = code;
                        state_next      = MEASURE;
                    end
                end else if (saturated) begin
                    state_next      = IDLE;
                    cand_valid_next = 1'b0;
                    error_next      = 1'b1;
                end
            end
            default: begin
                state_next      = IDLE;
                cand_valid_next = 1'b0;
            end
        endcase
        valid_next = (state_next == LOCKED);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg      <= IDLE;
            sig_q          <= 1'b0;
            cnt_reg        <= 5'd0;
            cand_valid_reg <= 1'b0;
            cand_code_reg  <= 2'b00;
            selector_o     <= 2'b00;
            valid_o        <= 1'b0;
            error_o        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            sig_q          <= sig_i;
            cnt_reg        <= cnt_next;
            cand_valid_reg <= cand_valid_next;
            cand_code_reg  <= cand_code_next;
            selector_o     <= selector_next;
            valid_o        <= valid_next;
            error_o        <= error_next;
        end
    end

endmodule
